// File: rtl/ct_check_pkg.sv
// Shared types and tuple helper for the constant-time observation checker.
// TW and mk_tuple describe the default ridecore widths (CT_CW, CT_AW).
package ct_check_pkg;

  typedef enum logic [1:0] {
    VkNone     = 2'd0,
    VkData     = 2'd1,
    VkOverflow = 2'd2,
    VkSkew     = 2'd3
  } viol_kind_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StFail  = 2'd2
  } chk_state_e;

  localparam int unsigned CT_CW = 2;
  localparam int unsigned CT_AW = 32;
  localparam int unsigned TW    = CT_CW + 1 + CT_AW;

  // A squashed cycle retires nothing; an address only counts when the access is valid.
  function automatic logic [TW-1:0] mk_tuple(input logic [CT_CW-1:0] commit,
                                             input logic             squash,
                                             input logic             mvalid,
                                             input logic [CT_AW-1:0] maddr);
    logic [CT_CW-1:0] ec;
    logic [CT_AW-1:0] addr;
    ec   = squash ? {CT_CW{1'b0}} : commit;
    addr = mvalid ? maddr : {CT_AW{1'b0}};
    return {ec, mvalid, addr};
  endfunction

endpackage

// File: rtl/ct_obs_fifo.sv
// Per-copy event FIFO; a push into a full FIFO is accepted only alongside a pop.
// Contents are invisible until the cycle after the push (no bypass).
module ct_obs_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TW    = 35
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [TW-1:0] din,
  output logic          full,
  output logic          empty,
  output logic [TW-1:0] head
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [TW-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [PW:0]   cnt_q;
  logic          do_pop, do_push;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (PW + 1)'(DEPTH));
  assign head    = mem_q[rd_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q        <= wr_q + PW'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + PW'(1);
      end
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + (PW + 1)'(1);
      end else if (!do_push && do_pop) begin
        cnt_q <= cnt_q - (PW + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/ct_obs_skew_checker.sv
// N-copy observation divergence checker: cycle-exact (MODE 0) or order-only with
// skew-absorbing FIFOs (MODE 1). The first detection is latched until rst.
module ct_obs_skew_checker
  import ct_check_pkg::*;
#(
  parameter int unsigned NCOPY    = 2,
  parameter int unsigned CW       = 2,
  parameter int unsigned AW       = 32,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned MAX_SKEW = 4,
  parameter int unsigned MODE     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NCOPY*CW-1:0]      obs_commit,
  input  logic [NCOPY-1:0]         obs_squash,
  input  logic [NCOPY-1:0]         obs_mvalid,
  input  logic [NCOPY*AW-1:0]      obs_maddr,
  output logic                     violation,
  output logic [1:0]               viol_kind,
  output logic [$clog2(NCOPY)-1:0] viol_copy,
  output logic [31:0]              viol_cycle,
  output logic [1:0]               state
);

  localparam int unsigned TUPLE_W = CW + 1 + AW;
  localparam int unsigned CPW     = $clog2(NCOPY);
  localparam int unsigned SKW     = $clog2(MAX_SKEW + 1);
  localparam logic [SKW-1:0] SKEW_LAST = SKW'(MAX_SKEW - 1);

  chk_state_e         state_q, state_d;
  logic [TUPLE_W-1:0] tup  [NCOPY];
  logic [TUPLE_W-1:0] head [NCOPY];
  logic [TUPLE_W-1:0] cmp  [NCOPY];
  logic [NCOPY-1:0]   tup_idle, push, fifo_full, fifo_empty;
  logic               active, flush, pipe_run, pop_all, all_ne, skewed, data_valid;
  logic               ovf_hit, data_hit, skew_hit, hit;
  logic [CPW-1:0]     ovf_copy, data_copy, skew_copy, copy_d, copy_q;
  viol_kind_e         kind_d, kind_q;
  logic [SKW-1:0]     skew_q, skew_d;
  logic [31:0]        cyc_q, vcyc_q;
  logic               viol_q;

  assign active     = (state_q == StArmed) && en;
  assign flush      = (state_q == StArmed) && !en;
  // The FIFOs keep draining after a detection; only the capture registers freeze.
  assign pipe_run   = active || (state_q == StFail);
  assign all_ne     = &(~fifo_empty);
  assign skewed     = (|(~fifo_empty)) && (|fifo_empty);
  assign pop_all    = pipe_run && all_ne;
  assign data_valid = (MODE == 1) ? all_ne : 1'b1;

  for (genvar i = 0; i < NCOPY; i++) begin : g_tuple
    logic [CW-1:0] ec;
    logic [AW-1:0] addr;
    assign ec          = obs_squash[i] ? {CW{1'b0}} : obs_commit[i*CW +: CW];
    assign addr        = obs_mvalid[i] ? obs_maddr[i*AW +: AW] : {AW{1'b0}};
    assign tup[i]      = {ec, obs_mvalid[i], addr};
    assign tup_idle[i] = (ec == '0) && !obs_mvalid[i];
    assign push[i]     = pipe_run && !tup_idle[i];
    assign cmp[i]      = (MODE == 1) ? head[i] : tup[i];
  end

  if (MODE == 1) begin : g_fifo
    for (genvar i = 0; i < NCOPY; i++) begin : g_copy
      ct_obs_fifo #(
        .DEPTH (DEPTH),
        .TW    (TUPLE_W)
      ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push[i]),
        .pop   (pop_all),
        .din   (tup[i]),
        .full  (fifo_full[i]),
        .empty (fifo_empty[i]),
        .head  (head[i])
      );
    end
  end else begin : g_nofifo
    assign fifo_full  = '0;
    assign fifo_empty = '1;
    for (genvar i = 0; i < NCOPY; i++) begin : g_copy
      assign head[i] = '0;
    end
  end

  // Descending scans so the lowest offending copy index wins.
  always_comb begin
    ovf_hit   = 1'b0;
    ovf_copy  = '0;
    data_hit  = 1'b0;
    data_copy = '0;
    skew_copy = '0;
    for (int i = NCOPY - 1; i >= 0; i--) begin
      if (push[i] && fifo_full[i] && !pop_all) begin
        ovf_hit  = 1'b1;
        ovf_copy = CPW'(i);
      end
      if (fifo_empty[i]) begin
        skew_copy = CPW'(i);
      end
    end
    for (int i = NCOPY - 1; i >= 1; i--) begin
      if (cmp[i] != cmp[0]) begin
        data_hit  = 1'b1;
        data_copy = CPW'(i);
      end
    end
    data_hit = data_hit && data_valid;
    skew_hit = skewed && (skew_q == SKEW_LAST);
    skew_d   = (active && skewed) ? skew_q + SKW'(1) : '0;
  end

  always_comb begin
    hit    = 1'b0;
    kind_d = VkNone;
    copy_d = '0;
    if (active) begin
      if (ovf_hit) begin
        hit    = 1'b1;
        kind_d = VkOverflow;
        copy_d = ovf_copy;
      end else if (data_hit) begin
        hit    = 1'b1;
        kind_d = VkData;
        copy_d = data_copy;
      end else if (skew_hit) begin
        hit    = 1'b1;
        kind_d = VkSkew;
        copy_d = skew_copy;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (en) state_d = StArmed;
      StArmed: begin
        if (!en) begin
          state_d = StIdle;
        end else if (hit) begin
          state_d = StFail;
        end
      end
      StFail:  state_d = StFail;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      skew_q  <= '0;
      cyc_q   <= '0;
      viol_q  <= 1'b0;
      kind_q  <= VkNone;
      copy_q  <= '0;
      vcyc_q  <= '0;
    end else begin
      state_q <= state_d;
      skew_q  <= skew_d;
      if (flush) begin
        cyc_q <= '0;
      end else if (active) begin
        cyc_q <= cyc_q + 32'd1;
      end
      if (hit) begin
        viol_q <= 1'b1;
        kind_q <= kind_d;
        copy_q <= copy_d;
        vcyc_q <= cyc_q;
      end
    end
  end

  assign violation  = viol_q;
  assign viol_kind  = kind_q;
  assign viol_copy  = copy_q;
  assign viol_cycle = vcyc_q;
  assign state      = state_q;

endmodule

// File: tb/tb_ct_obs_skew_checker.sv
// Three checker configurations share one stimulus stream; a queue-based model of the
// observation rules predicts every output each cycle, alongside directed expectations.
module tb_ct_obs_skew_checker;
  import ct_check_pkg::*;

  localparam int NDUT = 3;
  localparam int CFG_MODE  [NDUT] = '{0, 1, 1};
  localparam int CFG_DEPTH [NDUT] = '{8, 8, 4};
  localparam int CFG_SKEW  [NDUT] = '{4, 4, 16};

  logic        clk = 1'b0;
  logic        rst, en;
  logic [3:0]  commit;
  logic [1:0]  squash, mvalid;
  logic [63:0] maddr;

  logic        d_viol  [NDUT];
  logic [1:0]  d_kind  [NDUT];
  logic        d_copy  [NDUT];
  logic [31:0] d_cyc   [NDUT];
  logic [1:0]  d_state [NDUT];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ct_obs_skew_checker #(.NCOPY(2), .CW(2), .AW(32), .DEPTH(8), .MAX_SKEW(4), .MODE(0)) u_m0 (
    .clk(clk), .rst(rst), .en(en), .obs_commit(commit), .obs_squash(squash),
    .obs_mvalid(mvalid), .obs_maddr(maddr), .violation(d_viol[0]), .viol_kind(d_kind[0]),
    .viol_copy(d_copy[0]), .viol_cycle(d_cyc[0]), .state(d_state[0]));

  ct_obs_skew_checker #(.NCOPY(2), .CW(2), .AW(32), .DEPTH(8), .MAX_SKEW(4), .MODE(1)) u_m1 (
    .clk(clk), .rst(rst), .en(en), .obs_commit(commit), .obs_squash(squash),
    .obs_mvalid(mvalid), .obs_maddr(maddr), .violation(d_viol[1]), .viol_kind(d_kind[1]),
    .viol_copy(d_copy[1]), .viol_cycle(d_cyc[1]), .state(d_state[1]));

  ct_obs_skew_checker #(.NCOPY(2), .CW(2), .AW(32), .DEPTH(4), .MAX_SKEW(16), .MODE(1)) u_m2 (
    .clk(clk), .rst(rst), .en(en), .obs_commit(commit), .obs_squash(squash),
    .obs_mvalid(mvalid), .obs_maddr(maddr), .violation(d_viol[2]), .viol_kind(d_kind[2]),
    .viol_copy(d_copy[2]), .viol_cycle(d_cyc[2]), .state(d_state[2]));

  // Reference model: 0 idle, 1 armed, 2 failed; one event queue per copy.
  int          m_st   [NDUT];
  logic        m_viol [NDUT];
  int          m_kind [NDUT];
  int          m_copy [NDUT];
  logic [31:0] m_cyc  [NDUT];
  logic [31:0] m_vcyc [NDUT];
  int          m_run  [NDUT];
  logic [TW-1:0] mq [NDUT][2][$];

  task automatic model_clear(input int k);
    m_cyc[k] = 0;
    m_run[k] = 0;
    for (int i = 0; i < 2; i++) mq[k][i].delete();
  endtask

  task automatic model_step(input int k);
    logic [TW-1:0] t [2];
    bit idl [2];
    bit both, any_e, any_ne;
    int ovf, dat, skc;
    for (int i = 0; i < 2; i++) begin
      t[i]   = mk_tuple(commit[i*2 +: 2], squash[i], mvalid[i], maddr[i*32 +: 32]);
      idl[i] = (squash[i] || commit[i*2 +: 2] == 2'd0) && !mvalid[i];
    end
    if (rst) begin
      m_st[k] = 0; m_viol[k] = 0; m_kind[k] = 0; m_copy[k] = 0; m_vcyc[k] = 0;
      model_clear(k);
      return;
    end
    if (m_st[k] == 0) begin
      if (en) m_st[k] = 1;
    end else if (m_st[k] == 1) begin
      if (!en) begin
        model_clear(k);
        m_st[k] = 0;
      end else begin
        ovf = -1; dat = -1; skc = -1;
        both   = (mq[k][0].size() > 0) && (mq[k][1].size() > 0);
        any_e  = (mq[k][0].size() == 0) || (mq[k][1].size() == 0);
        any_ne = (mq[k][0].size() > 0) || (mq[k][1].size() > 0);
        if (CFG_MODE[k] == 0) begin
          if (t[1] != t[0]) dat = 1;
        end else begin
          if (both && mq[k][1][0] != mq[k][0][0]) dat = 1;
          for (int i = 1; i >= 0; i--)
            if (!idl[i] && mq[k][i].size() == CFG_DEPTH[k] && !both) ovf = i;
          if (any_e && any_ne) begin
            m_run[k]++;
            if (m_run[k] == CFG_SKEW[k]) skc = (mq[k][0].size() == 0) ? 0 : 1;
          end else begin
            m_run[k] = 0;
          end
          if (both) for (int i = 0; i < 2; i++) void'(mq[k][i].pop_front());
          for (int i = 0; i < 2; i++)
            if (!idl[i] && mq[k][i].size() < CFG_DEPTH[k]) mq[k][i].push_back(t[i]);
        end
        if (ovf >= 0 || dat >= 0 || skc >= 0) begin
          m_st[k]   = 2;
          m_viol[k] = 1;
          m_vcyc[k] = m_cyc[k];
          if (ovf >= 0) begin m_kind[k] = 2; m_copy[k] = ovf; end
          else if (dat >= 0) begin m_kind[k] = 1; m_copy[k] = dat; end
          else begin m_kind[k] = 3; m_copy[k] = skc; end
        end
        m_cyc[k] = m_cyc[k] + 32'd1;
      end
    end
  endtask

  task automatic check_model(input int k);
    checks++;
    if (d_state[k] !== 2'(m_st[k]) || d_viol[k] !== m_viol[k] || d_kind[k] !== 2'(m_kind[k])
        || d_copy[k] !== 1'(m_copy[k]) || d_cyc[k] !== m_vcyc[k]) begin
      errors++;
      $display("FAIL model_dut%0d t=%0t got st=%0d v=%0b kind=%0d copy=%0d cyc=%0d want st=%0d v=%0b kind=%0d copy=%0d cyc=%0d",
               k, $time, d_state[k], d_viol[k], d_kind[k], d_copy[k], d_cyc[k],
               m_st[k], m_viol[k], m_kind[k], m_copy[k], m_vcyc[k]);
    end
  endtask

  task automatic expect_out(input string name, input int k, input logic [1:0] st, input logic v,
                            input logic [1:0] kd, input logic cp, input logic [31:0] cy);
    checks++;
    if (d_state[k] !== st || d_viol[k] !== v || d_kind[k] !== kd || d_copy[k] !== cp ||
        d_cyc[k] !== cy) begin
      errors++;
      $display("FAIL %s dut%0d got st=%0d v=%0b kind=%0d copy=%0d cyc=%0d want st=%0d v=%0b kind=%0d copy=%0d cyc=%0d",
               name, k, d_state[k], d_viol[k], d_kind[k], d_copy[k], d_cyc[k], st, v, kd, cp, cy);
    end
  endtask

  task automatic tick();
    for (int k = 0; k < NDUT; k++) model_step(k);
    @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) check_model(k);
  endtask

  task automatic drive(input logic r, input logic e, input logic [1:0] c0, input logic m0,
                       input logic [31:0] a0, input logic [1:0] c1, input logic m1,
                       input logic [31:0] a1);
    rst = r; en = e; commit = {c1, c0}; squash = 2'b00; mvalid = {m1, m0}; maddr = {a1, a0};
  endtask

  task automatic reset_and_arm();
    drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 0, 0, 0); tick();
  endtask

  typedef struct {
    logic        rst, en;
    logic [3:0]  commit;
    logic [1:0]  squash, mvalid;
    logic [63:0] maddr;
    logic [1:0]  st;
    logic        viol;
    logic [1:0]  kind;
    logic        copy;
    logic [31:0] cyc;
  } vec_t;

  function automatic vec_t mkv(input logic r, input logic e, input logic [3:0] c,
                               input logic [1:0] s, input logic [1:0] m, input logic [63:0] a,
                               input logic [1:0] st, input logic v, input logic [1:0] kd,
                               input logic cp, input logic [31:0] cy);
    vec_t x;
    x.rst = r; x.en = e; x.commit = c; x.squash = s; x.mvalid = m; x.maddr = a;
    x.st = st; x.viol = v; x.kind = kd; x.copy = cp; x.cyc = cy;
    return x;
  endfunction

  function automatic logic [35:0] rnd_obs();
    logic [1:0]  c;
    logic        s, m;
    logic [31:0] a;
    c = 2'($urandom_range(0, 3));
    s = ($urandom_range(0, 5) == 0);
    m = ($urandom_range(0, 1) == 1);
    a = 32'h100 + 32'($urandom_range(0, 2)) * 32'd4;
    if ($urandom_range(0, 1) == 0) begin
      c = 2'd0; m = 1'b0; a = $urandom;
    end
    return {c, s, m, a};
  endfunction

  vec_t        vecs [16];
  logic [35:0] hist [8];
  logic [35:0] r0, r1;
  int          scen, dly;

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      m_st[k] = 0; m_viol[k] = 0; m_kind[k] = 0; m_copy[k] = 0; m_vcyc[k] = 0;
      m_cyc[k] = 0; m_run[k] = 0;
    end
    vecs[0]  = mkv(1, 0, 4'b0000, 2'b00, 2'b00, 64'h0, 0, 0, 0, 0, 0);
    vecs[1]  = mkv(0, 1, 4'b1010, 2'b00, 2'b00, 64'h0, 1, 0, 0, 0, 0);
    vecs[2]  = mkv(0, 1, 4'b1010, 2'b00, 2'b00, 64'h0, 1, 0, 0, 0, 0);
    vecs[3]  = mkv(0, 1, 4'b0010, 2'b01, 2'b00, 64'h0, 1, 0, 0, 0, 0);
    vecs[4]  = mkv(0, 1, 4'b0101, 2'b00, 2'b11, 64'h00000100_00000100, 1, 0, 0, 0, 0);
    vecs[5]  = mkv(0, 1, 4'b0110, 2'b00, 2'b00, 64'h0, 2, 1, 1, 1, 3);
    vecs[6]  = mkv(0, 0, 4'b0000, 2'b00, 2'b00, 64'h0, 2, 1, 1, 1, 3);
    vecs[7]  = mkv(1, 0, 4'b0000, 2'b00, 2'b00, 64'h0, 0, 0, 0, 0, 0);
    vecs[8]  = mkv(0, 1, 4'b0000, 2'b00, 2'b00, 64'h0, 1, 0, 0, 0, 0);
    vecs[9]  = mkv(0, 1, 4'b0000, 2'b00, 2'b11, 64'h00000104_00000100, 2, 1, 1, 1, 0);
    vecs[10] = mkv(1, 0, 4'b0000, 2'b00, 2'b00, 64'h0, 0, 0, 0, 0, 0);
    vecs[11] = mkv(0, 1, 4'b0000, 2'b00, 2'b00, 64'h0, 1, 0, 0, 0, 0);
    vecs[12] = mkv(0, 1, 4'b0000, 2'b00, 2'b00, 64'h00000007_00000005, 1, 0, 0, 0, 0);
    vecs[13] = mkv(0, 0, 4'b0000, 2'b00, 2'b00, 64'h0, 0, 0, 0, 0, 0);
    vecs[14] = mkv(0, 1, 4'b0000, 2'b00, 2'b00, 64'h0, 1, 0, 0, 0, 0);
    vecs[15] = mkv(0, 1, 4'b1100, 2'b00, 2'b00, 64'h0, 2, 1, 1, 1, 0);

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 16; n++) begin
      rst = vecs[n].rst; en = vecs[n].en; commit = vecs[n].commit;
      squash = vecs[n].squash; mvalid = vecs[n].mvalid; maddr = vecs[n].maddr;
      tick();
      expect_out($sformatf("vec%0d", n), 0, vecs[n].st, vecs[n].viol, vecs[n].kind,
                 vecs[n].copy, vecs[n].cyc);
    end

    // Order-only: a 3-cycle skew is absorbed, then a lone push trips SKEW after 4 cycles.
    reset_and_arm();
    for (int k = 0; k < 14; k++) begin
      drive(0, 1, 0, (k == 3 || k == 9), (k == 9) ? 32'h200 : 32'h100, 0, (k == 6), 32'h100);
      tick();
      if (k == 12) expect_out("skew_absorbed", 1, 1, 0, 0, 0, 0);
    end
    expect_out("skew_trip", 1, 2, 1, 3, 1, 13);
    expect_out("skew16_quiet", 2, 1, 0, 0, 0, 0);

    // Five pushes from copy 0 only: OVERFLOW in the depth-4 copy, SKEW in the depth-8 copy.
    reset_and_arm();
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 1, 0, 0, 0, 0, 0);
      tick();
      if (k == 3) expect_out("ovf_pre", 2, 1, 0, 0, 0, 0);
    end
    expect_out("ovf_trip", 2, 2, 1, 2, 0, 4);
    expect_out("ovf_skew_side", 1, 2, 1, 3, 1, 4);

    // Differing heads compare one cycle after the later push.
    reset_and_arm();
    drive(0, 1, 1, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 2, 0, 0); tick();
    expect_out("data_pre", 1, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0); tick();
    expect_out("data_trip1", 1, 2, 1, 1, 1, 2);
    expect_out("data_trip2", 2, 2, 1, 1, 1, 2);

    // Dropping en must flush the partly filled FIFO and the cycle counter.
    reset_and_arm();
    drive(0, 1, 1, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 1, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
    expect_out("disarm_idle", 1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 2, 0, 0); tick();
    for (int k = 1; k < 5; k++) begin
      drive(0, 1, 0, 0, 0, 0, 0, 0); tick();
    end
    expect_out("flushed_skew", 1, 2, 1, 3, 0, 4);

    // Random phase: independent, mirrored or delayed copy-1 streams.
    scen = 1; dly = 1;
    for (int j = 0; j < 8; j++) hist[j] = '0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1; scen = $urandom_range(0, 2); dly = $urandom_range(1, 6);
      end else begin
        rst = 1'b0;
      end
      en = ($urandom_range(0, 49) != 0);
      r0 = rnd_obs();
      case (scen)
        0:       r1 = rnd_obs();
        1:       r1 = r0;
        default: r1 = hist[dly-1];
      endcase
      for (int j = 7; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = r0;
      commit = {r1[35:34], r0[35:34]};
      squash = {r1[33], r0[33]};
      mvalid = {r1[32], r0[32]};
      maddr  = {r1[31:0], r0[31:0]};
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
